// File: rtl/test017_core.sv
// test017_core: four public 32-bit field registers plus a test(idx) method
// that overwrites the fields, reads them back, sums them and returns a pass flag.
// Ports: clk, reset (async, active-high); testN_in/testN_we/testN_out per field;
//        test_idx, test_req (level) in; test_busy, test_return out.
module test017_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] test0_in,
  input  logic        test0_we,
  input  logic [31:0] test1_in,
  input  logic        test1_we,
  input  logic [31:0] test2_in,
  input  logic        test2_we,
  input  logic [31:0] test3_in,
  input  logic        test3_we,
  output logic [31:0] test0_out,
  output logic [31:0] test1_out,
  output logic [31:0] test2_out,
  output logic [31:0] test3_out,
  input  logic [31:0] test_idx,
  input  logic        test_req,
  output logic        test_busy,
  output logic        test_return
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_W0    = 3'd1,
    S_W1    = 3'd2,
    S_W2    = 3'd3,
    S_W3    = 3'd4,
    S_SUM   = 3'd5,
    S_CHECK = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] idx;
  logic [31:0] acc;
  logic [31:0] fld [0:3];
  logic [31:0] ext_dat [0:3];
  logic [3:0]  ext_we;
  logic [3:0]  m_we;
  logic [31:0] m_dat;
  logic        chk_pass;

  assign ext_we     = {test3_we, test2_we, test1_we, test0_we};
  assign ext_dat[0] = test0_in;
  assign ext_dat[1] = test1_in;
  assign ext_dat[2] = test2_in;
  assign ext_dat[3] = test3_in;

  assign test0_out = fld[0];
  assign test1_out = fld[1];
  assign test2_out = fld[2];
  assign test3_out = fld[3];

  // Readback check: the accumulated sum plus each field against its
  // expected value, so a late external write is caught even when it does
  // not disturb the sum.
  assign chk_pass = (acc == ((idx << 2) + 32'd10)) &&
                    (fld[0] == idx + 32'd1) &&
                    (fld[1] == idx + 32'd2) &&
                    (fld[2] == idx + 32'd3) &&
                    (fld[3] == idx + 32'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    m_we      = 4'b0000;
    m_dat     = 32'd0;
    test_busy = 1'b1;
    case (state)
      S_IDLE: begin
        test_busy = 1'b0;
        if (test_req) state_nxt = S_W0;
      end
      S_W0: begin
        m_we[0]   = 1'b1;
        m_dat     = idx + 32'd1;
        state_nxt = S_W1;
      end
      S_W1: begin
        m_we[1]   = 1'b1;
        m_dat     = idx + 32'd2;
        state_nxt = S_W2;
      end
      S_W2: begin
        m_we[2]   = 1'b1;
        m_dat     = idx + 32'd3;
        state_nxt = S_W3;
      end
      S_W3: begin
        m_we[3]   = 1'b1;
        m_dat     = idx + 32'd4;
        state_nxt = S_SUM;
      end
      S_SUM:   state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_IDLE;
      default: begin
        test_busy = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Method writes take priority over an external write to the same field.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) fld[i] <= 32'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (m_we[i])       fld[i] <= m_dat;
        else if (ext_we[i]) fld[i] <= ext_dat[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx         <= 32'd0;
      acc         <= 32'd0;
      test_return <= 1'b0;
    end else begin
      if (state == S_IDLE && test_req) idx <= test_idx;
      if (state == S_SUM) acc <= fld[0] + fld[1] + fld[2] + fld[3];
      if (state == S_CHECK) test_return <= chk_pass;
    end
  end

endmodule

// File: tb/tb_test017_core.sv
module tb_test017_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] test0_in, test1_in, test2_in, test3_in;
  logic        test0_we, test1_we, test2_we, test3_we;
  logic [31:0] test0_out, test1_out, test2_out, test3_out;
  logic [31:0] test_idx;
  logic        test_req;
  logic        test_busy;
  logic        test_return;

  int checks   = 0;
  int failures = 0;

  test017_core dut (
    .clk         (clk),
    .reset       (reset),
    .test0_in    (test0_in),
    .test0_we    (test0_we),
    .test1_in    (test1_in),
    .test1_we    (test1_we),
    .test2_in    (test2_in),
    .test2_we    (test2_we),
    .test3_in    (test3_in),
    .test3_we    (test3_we),
    .test0_out   (test0_out),
    .test1_out   (test1_out),
    .test2_out   (test2_out),
    .test3_out   (test3_out),
    .test_idx    (test_idx),
    .test_req    (test_req),
    .test_busy   (test_busy),
    .test_return (test_return)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_fields(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    check({tag, "_f0"}, test0_out, e0);
    check({tag, "_f1"}, test1_out, e1);
    check({tag, "_f2"}, test2_out, e2);
    check({tag, "_f3"}, test3_out, e3);
  endtask

  initial begin
    reset    = 1'b1;
    test0_in = '0; test1_in = '0; test2_in = '0; test3_in = '0;
    test0_we = 1'b0; test1_we = 1'b0; test2_we = 1'b0; test3_we = 1'b0;
    test_idx = '0;
    test_req = 1'b0;

    // 1. Reset state
    step();
    step();
    reset = 1'b0;
    step();
    check_fields("rst", 32'd0, 32'd0, 32'd0, 32'd0);
    check("rst_busy", 32'(test_busy), 32'd0);
    check("rst_ret", 32'(test_return), 32'd0);

    // 2. External write of field 0
    test0_in = 32'hDEADBEEF;
    test0_we = 1'b1;
    step();
    test0_we = 1'b0;
    check_fields("ext_wr", 32'hDEADBEEF, 32'd0, 32'd0, 32'd0);
    step();
    check("ext_hold", test0_out, 32'hDEADBEEF);

    // 3. idx = 0 with req held: two back-to-back calls
    test_idx = 32'd0;
    test_req = 1'b1;
    check("c0_busy_pre", 32'(test_busy), 32'd0);
    for (int c = 1; c <= 6; c++) begin
      step();
      check($sformatf("c0_busy_%0d", c), 32'(test_busy), 32'd1);
    end
    step();
    check("c0_busy_done", 32'(test_busy), 32'd0);
    check("c0_ret", 32'(test_return), 32'd1);
    check_fields("c0", 32'd1, 32'd2, 32'd3, 32'd4);
    // req still high: the next call starts after this single idle cycle
    step();
    check("c0b_busy", 32'(test_busy), 32'd1);
    test_req = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      step();
      check($sformatf("c0b_ret_held_%0d", c), 32'(test_return), 32'd1);
    end
    step();
    check("c0b_busy_done", 32'(test_busy), 32'd0);
    check("c0b_ret", 32'(test_return), 32'd1);
    step();
    check("c0b_no_restart", 32'(test_busy), 32'd0);

    // 4. idx = 0xFFFFFFFF wraps; external write to field 0 colliding with W0 loses
    test_idx = 32'hFFFFFFFF;
    test_req = 1'b1;
    step();
    test_req = 1'b0;
    test0_in = 32'h12345678;
    test0_we = 1'b1;
    step();
    test0_we = 1'b0;
    check("wrap_prio", test0_out, 32'd0);
    for (int c = 0; c < 5; c++) step();
    check("wrap_busy", 32'(test_busy), 32'd0);
    check("wrap_ret", 32'(test_return), 32'd1);
    check_fields("wrap", 32'd0, 32'd1, 32'd2, 32'd3);

    // 5. idx = 5, field 2 overwritten with 0 during SUM
    test_idx = 32'd5;
    test_req = 1'b1;
    step();
    test_req = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("corr_in_sum", 32'(test_busy), 32'd1);
    test2_in = 32'd0;
    test2_we = 1'b1;
    step();
    test2_we = 1'b0;
    step();
    check("corr_busy", 32'(test_busy), 32'd0);
    check("corr_ret", 32'(test_return), 32'd0);
    check_fields("corr", 32'd6, 32'd7, 32'd0, 32'd9);

    // Good call so the return flag is 1 before the reset test
    test_idx = 32'd7;
    test_req = 1'b1;
    step();
    test_req = 1'b0;
    for (int c = 0; c < 6; c++) step();
    check("pre_rst_ret", 32'(test_return), 32'd1);
    check_fields("pre_rst", 32'd8, 32'd9, 32'd10, 32'd11);

    // 6. Reset asserted during W2 takes effect without a clock edge
    test_idx = 32'd100;
    test_req = 1'b1;
    step();
    test_req = 1'b0;
    step();
    step();
    check("mid_busy_w2", 32'(test_busy), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(test_busy), 32'd0);
    check("mid_rst_ret", 32'(test_return), 32'd0);
    check_fields("mid_rst", 32'd0, 32'd0, 32'd0, 32'd0);
    step();
    reset = 1'b0;
    step();
    check("post_rst_idle", 32'(test_busy), 32'd0);
    check_fields("post_rst", 32'd0, 32'd0, 32'd0, 32'd0);

    // Fresh call after reset proves the FSM restarted from IDLE
    test_idx = 32'h80000000;
    test_req = 1'b1;
    step();
    test_req = 1'b0;
    check("post_busy", 32'(test_busy), 32'd1);
    for (int c = 0; c < 6; c++) step();
    check("post_busy_done", 32'(test_busy), 32'd0);
    check("post_ret", 32'(test_return), 32'd1);
    check_fields("post", 32'h80000001, 32'h80000002, 32'h80000003, 32'h80000004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
